divctl_hilo: RTL
================

Name: divctl_hilo

Overview:
- Control and writeback stage wrapped around the iterative divider.
- Decodes DIV/MTHI/MTLO requests from the datapath and launches the divider with a single start pulse.
- Waits for the divider's ready, then commits quotient/remainder into the architectural HI/LO registers.
- Stalls the pipeline while a division is in flight and raises a one-cycle divide-by-zero exception to the control unit.

Parameters:
- DRAIN_CYCLES, 34, cycles spent in DRAIN after reset so an interrupted divider run completes and is discarded.
- TIMEOUT, 40, max cycles in WAIT before abandoning the operation.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- op_div  input  1  launch DIV on rs_data / rt_data
- op_mthi  input  1  write rs_data to HI
- op_mtlo  input  1  write rs_data to LO
- op_mfhi  input  1  HI read request (stall qualification only)
- op_mflo  input  1  LO read request (stall qualification only)
- rs_data  input  32  dividend / MTHI / MTLO source
- rt_data  input  32  divisor
- div_start  output  1  start pulse to divider
- div_a  output  32  dividend to divider
- div_b  output  32  divisor to divider
- div_hi  input  32  divider remainder
- div_lo  input  32  divider quotient
- div_ready  input  1  divider completion pulse
- div_zero  input  1  divider zero-divisor flag, valid with div_ready
- hi_out  output  32  architectural HI
- lo_out  output  32  architectural LO
- busy  output  1  unit not in IDLE
- stall  output  1  pipeline hold request
- exc_div_zero  output  1  one-cycle divide-by-zero exception
- err_timeout  output  1  one-cycle watchdog error

Behaviour:
- Reset (sync, high):
  - hi_out=0, lo_out=0, div_start=0, div_a=0, div_b=0, exc_div_zero=0, err_timeout=0.
  - State forced to DRAIN with drain counter = DRAIN_CYCLES. Applies mid-operation too; any in-flight result is lost.
- States:
  - DRAIN: busy=1; div_ready ignored; counter decrements each cycle; at 0 -> IDLE.
  - IDLE: busy=0. Request priority op_div > op_mthi > op_mtlo; lower-priority ops in the same cycle are dropped.
    - op_div: register div_a/div_b from rs/rt; div_start=1 next cycle; -> WAIT; watchdog cleared.
    - op_mthi: hi_out<=rs_data on the next edge.
    - op_mtlo: lo_out<=rs_data on the next edge.
  - WAIT:
    - busy=1; div_start high only on the first WAIT cycle (exactly one cycle per DIV); div_a/div_b held stable.
    - On div_ready with div_zero=1: exc_div_zero=1 for one cycle; HI/LO unchanged; -> IDLE.
    - On div_ready with div_zero=0: hi_out<=div_hi, lo_out<=div_lo (post-processed if the feature is enabled); -> IDLE.
    - Watchdog counts WAIT cycles; reaching TIMEOUT without div_ready gives err_timeout=1 for one cycle; HI/LO unchanged; -> DRAIN (reloaded).
    - op_* inputs during WAIT are not accepted.
- Stall: stall = busy & (op_div|op_mthi|op_mtlo|op_mfhi|op_mflo). Combinational.
- Latency:
  - hi_out/lo_out update on the edge where div_ready is sampled high; the new value is visible the cycle IDLE is re-entered.
  - Zero divisor: exception 2 cycles after op_div is accepted.
  - Nonzero divisor: about 36 cycles with the current divider.
  - Bench checks against TIMEOUT, not an exact count.
- div_ready seen in IDLE or DRAIN is ignored.
- exc_div_zero and err_timeout are never asserted together.

Optional Feature:
- Macro DIV_SIGNED_EN.
- Defined: DIV is signed (MIPS DIV).
  - div_a=|rs_data|, div_b=|rt_data|; operand signs latched at launch.
  - Quotient is negated when the signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 magnitude passes as unsigned 0x80000000. -2^31 / -1 gives lo=0x80000000, hi=0.
  - Zero-divisor handling is unchanged.
- Undefined: operands pass through unmodified and the result is committed raw (DIVU semantics). No sign logic is synthesized.

Test Plan:
- Reset asserted 1 cycle, then released -> hi_out=lo_out=0; busy=1 for 34 cycles, then 0; div_start never pulses.
- Idle, op_div rs=100 rt=7 -> div_start high exactly 1 cycle with div_a=100, div_b=7; busy until ready; then lo_out=14, hi_out=2, busy=0.
- HI=LO=5 preloaded, op_div rs=9 rt=0 -> exc_div_zero one-cycle pulse; hi_out=lo_out=5; back to IDLE.
- op_div in flight, op_mfhi held high -> stall=1 every cycle until the IDLE cycle, then 0; hi_out shows the new remainder.
- Idle, op_mthi rs=0xDEADBEEF -> hi_out=0xDEADBEEF next cycle; same cycle op_div+op_mtlo -> division launched, LO not written by MTLO.
- Macro defined, op_div rs=0xFFFFFFF9 (-7) rt=2 -> lo_out=0xFFFFFFFD, hi_out=0xFFFFFFFF. Macro undefined, same stimulus -> lo_out=0x7FFFFFFC, hi_out=1.

Source files
------------

// File: rtl/divctl_hilo_if.sv
// divctl_hilo_if: start/operand/result handshake between divctl_hilo and the iterative divider.
interface divctl_hilo_if;
  logic        div_start;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        div_ready;
  logic        div_zero;
  modport master (output div_start, div_a, div_b, input div_hi, div_lo, div_ready, div_zero);
  modport slave  (input div_start, div_a, div_b, output div_hi, div_lo, div_ready, div_zero);
endinterface

// File: rtl/divctl_hilo.sv
// divctl_hilo: DIV/MTHI/MTLO control and HI/LO writeback around the iterative divider.
// Define DIV_SIGNED_EN for signed DIV (magnitudes to the divider, signs restored on commit).
module divctl_hilo #(
  parameter int DRAIN_CYCLES = 34,
  parameter int TIMEOUT      = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_div,
  input  logic               op_mthi,
  input  logic               op_mtlo,
  input  logic               op_mfhi,
  input  logic               op_mflo,
  input  logic [31:0]        rs_data,
  input  logic [31:0]        rt_data,
  divctl_hilo_if.master      dv,
  output logic [31:0]        hi_out,
  output logic [31:0]        lo_out,
  output logic               busy,
  output logic               stall,
  output logic               exc_div_zero,
  output logic               err_timeout
);
  localparam int CW = $clog2((DRAIN_CYCLES > TIMEOUT ? DRAIN_CYCLES : TIMEOUT) + 1);
  typedef enum logic [1:0] {DRAIN, IDLE, WAIT} state_t;
  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_start, r_exc, r_tmo;
  logic [31:0]     r_a, r_b, r_hi, r_lo;
  logic [31:0]     w_a, w_b, w_hi, w_lo;
  logic            w_launch, w_done, w_tmo;
`ifdef DIV_SIGNED_EN
  logic r_sa, r_sb;
  assign w_a  = rs_data[31] ? -rs_data : rs_data;
  assign w_b  = rt_data[31] ? -rt_data : rt_data;
  assign w_lo = (r_sa ^ r_sb) ? -dv.div_lo : dv.div_lo;
  assign w_hi = r_sa ? -dv.div_hi : dv.div_hi;
  always_ff @(posedge clk)
    if (reset) begin
      r_sa <= 1'b0;
      r_sb <= 1'b0;
    end else if (w_launch) begin
      r_sa <= rs_data[31];
      r_sb <= rt_data[31];
    end
`else
  assign w_a  = rs_data;
  assign w_b  = rt_data;
  assign w_lo = dv.div_lo;
  assign w_hi = dv.div_hi;
`endif
  always_comb begin
    w_launch = r_state == IDLE && op_div;
    w_done   = r_state == WAIT && dv.div_ready;
    w_tmo    = r_state == WAIT && !dv.div_ready && r_cnt == CW'(TIMEOUT - 1);
    w_next   = (r_state == DRAIN && r_cnt <= CW'(1)) ? IDLE :
               w_launch ? WAIT :
               w_done   ? IDLE :
               w_tmo    ? DRAIN : r_state;
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= DRAIN;
      r_cnt   <= CW'(DRAIN_CYCLES);
      r_start <= 1'b0;
      r_exc   <= 1'b0;
      r_tmo   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_next;
      r_start <= w_launch;
      r_exc   <= w_done && dv.div_zero;
      r_tmo   <= w_tmo;
      if (r_state == DRAIN) r_cnt <= r_cnt - CW'(1);
      else if (w_launch) r_cnt <= '0;
      else if (w_tmo) r_cnt <= CW'(DRAIN_CYCLES);
      else if (r_state == WAIT) r_cnt <= r_cnt + CW'(1);
      if (w_launch) begin
        r_a <= w_a;
        r_b <= w_b;
      end
      if (r_state == IDLE && !op_div && op_mthi) r_hi <= rs_data;
      if (r_state == IDLE && !op_div && !op_mthi && op_mtlo) r_lo <= rs_data;
      if (w_done && !dv.div_zero) begin
        r_hi <= w_hi;
        r_lo <= w_lo;
      end
    end
  assign busy         = r_state != IDLE;
  assign stall        = busy & (op_div | op_mthi | op_mtlo | op_mfhi | op_mflo);
  assign dv.div_start = r_start;
  assign dv.div_a     = r_a;
  assign dv.div_b     = r_b;
  assign hi_out       = r_hi;
  assign lo_out       = r_lo;
  assign exc_div_zero = r_exc;
  assign err_timeout  = r_tmo;
endmodule
